seven_seg_scan_driver: RTL and testbench
========================================

SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 50000, giving the clock cycles each digit is lit (legal range 1..65535).
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 500, giving the all-off cycles after each digit (legal range 1..65535).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset: Clk  in  1  rising-edge clock.
REQ-004 The block SHALL have port Rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have port Enable  in  1  scan enable, level-sensitive.
REQ-006 The block SHALL have port Load  in  1  one-cycle request to capture new digit patterns.
REQ-007 The block SHALL have port SevenSegDig1  in  8  segment pattern for digit 1, passed through unmodified.
REQ-008 The block SHALL have port SevenSegDig2  in  8  segment pattern for digit 2, passed through unmodified.
REQ-009 The block SHALL have port SegOut  out  8  shared segment bus, registered.
REQ-010 The block SHALL have port DigitEn  out  2  one-hot digit strobe, registered; bit0 = digit 1, bit1 = digit 2.
REQ-011 The block SHALL have port FrameDone  out  1  one-cycle frame-end pulse.
REQ-012 The block SHALL have port LoadAck  out  1  one-cycle commit pulse.

Function
REQ-013 FSM states SHALL be IDLE, SHOW1, BLANK1, SHOW2 and BLANK2, with one 16-bit dwell counter cleared on every state entry.
REQ-014 In IDLE with Enable=1, the next cycle SHALL be SHOW1; with Enable=0, the block SHALL stay in IDLE.
REQ-015 SHOW1 and SHOW2 SHALL each last exactly DWELL_CYCLES cycles.
REQ-016 BLANK1 and BLANK2 SHALL each last exactly BLANK_CYCLES cycles.
REQ-017 The state order SHALL be SHOW1 -> BLANK1 -> SHOW2 -> BLANK2 -> SHOW1, giving a frame of 2*(DWELL_CYCLES+BLANK_CYCLES) cycles.
REQ-018 Output map: SHOW1 SHALL drive SegOut=disp1, DigitEn=01; SHOW2 SHALL drive SegOut=disp2, DigitEn=10; BLANK1, BLANK2 and IDLE SHALL drive SegOut=0, DigitEn=00.
REQ-019 DigitEn SHALL never be 11; no digit SHALL be lit in a cycle adjacent to the other digit's lit cycle.
REQ-020 Load=1 SHALL copy SevenSegDig1/2 into staging registers and set a pending flag; a later Load before commit SHALL overwrite staging (latest wins).
REQ-021 Commit SHALL occur only on entry to SHOW1 from IDLE or BLANK2: if pending, staging SHALL copy to disp1/disp2, pending SHALL clear, and LoadAck SHALL pulse in that first SHOW1 cycle.
REQ-022 If Load coincides with the commit cycle, the Load inputs themselves SHALL be committed and no pending flag SHALL remain (no tearing, no lost update).
REQ-023 Patterns SHALL never change mid-frame; disp1/disp2 SHALL alter only at commit.
REQ-024 FrameDone SHALL be 1 for exactly the final cycle of BLANK2 and SHALL be 0 otherwise.
REQ-025 Enable=0 in any non-IDLE state SHALL force IDLE on the next edge: outputs 0, counter cleared, pending and staging preserved.
REQ-026 Re-enable after IDLE SHALL restart at SHOW1, including commit.

Reset
REQ-027 Rst_n=0 SHALL immediately, with no clock edge, force state=IDLE, counter=0, staging=0, disp1=disp2=0, pending=0, SegOut=0, DigitEn=00, FrameDone=0 and LoadAck=0.
REQ-028 Reset mid-frame SHALL discard any pending Load; after release, behaviour SHALL follow REQ-014.

Structure
REQ-029 Shared package seven_seg_pkg SHALL hold the state enum and the default DWELL/BLANK constants.
REQ-030 The dwell counter with terminal-count compare SHALL be a sub-module named scan_timer; all other logic SHALL stay in seven_seg_scan_driver.

Verification (DWELL_CYCLES=4, BLANK_CYCLES=1)
REQ-031 Hold Rst_n=0 with arbitrary inputs -> SegOut=00, DigitEn=00, FrameDone=0 and LoadAck=0 throughout.
REQ-032 Load with SevenSegDig1=00000111 and SevenSegDig2=01110001, then Enable=1 -> 4 cycles of 00000111/01, then 1 cycle of 0/00, then 4 cycles of 01110001/10, then 1 cycle of 0/00 with FrameDone=1; LoadAck=1 on the first cycle.
REQ-033 Load 0x3F/0x06 during SHOW2 -> remainder of the frame still shows 0x07/0x71; next frame shows 0x3F/0x06 with LoadAck on its first SHOW1 cycle.
REQ-034 Load 0x5B/0x4F in the FrameDone cycle -> the next SHOW1 shows 0x5B immediately, LoadAck=1, and the following frame has no second LoadAck.
REQ-035 Enable=0 during the 2nd SHOW2 cycle -> next cycle SegOut=0, DigitEn=00; Enable=1 later -> SHOW1 resumes for the full 4 cycles.
REQ-036 Rst_n=0 mid-SHOW1 with Load pending -> outputs 0 without a clock edge; after release, disp1/disp2 read 0 and no LoadAck appears.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared types and defaults for the two-digit seven-segment scan driver.
package seven_seg_pkg;

  localparam int unsigned DefaultDwellCycles = 50000;
  localparam int unsigned DefaultBlankCycles = 500;
  localparam int unsigned CntWidth           = 16;

  typedef enum logic [2:0] {
    StIdle,
    StShow1,
    StBlank1,
    StShow2,
    StBlank2
  } scan_state_e;

endpackage

// File: rtl/scan_timer.sv
// Dwell counter: counts cycles since the last clear and flags the last cycle of a limit_i window.
module scan_timer
  import seven_seg_pkg::*;
(
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clear_i,
  input  logic [CntWidth-1:0] limit_i,
  output logic                tc_o
);

  logic [CntWidth-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clear_i ? '0 : cnt_q + CntWidth'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == limit_i - CntWidth'(1));

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Two-digit multiplexed seven-segment driver with blanking gaps and frame-aligned pattern commit.
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = DefaultDwellCycles,
  parameter int unsigned BLANK_CYCLES = DefaultBlankCycles
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Enable,
  input  logic       Load,
  input  logic [7:0] SevenSegDig1,
  input  logic [7:0] SevenSegDig2,
  output logic [7:0] SegOut,
  output logic [1:0] DigitEn,
  output logic       FrameDone,
  output logic       LoadAck
);

  localparam logic [CntWidth-1:0] DwellLimit = CntWidth'(DWELL_CYCLES);
  localparam logic [CntWidth-1:0] BlankLimit = CntWidth'(BLANK_CYCLES);

  scan_state_e         state_q, state_d;
  logic [7:0]          stage1_q, stage1_d, stage2_q, stage2_d;
  logic [7:0]          disp1_q, disp1_d, disp2_q, disp2_d;
  logic [7:0]          seg_q, seg_d;
  logic [1:0]          dig_q, dig_d;
  logic                pending_q, pending_d;
  logic                ack_q, ack_d;
  logic                tc, timer_clear, commit;
  logic [CntWidth-1:0] limit;

  assign limit = (state_q == StShow1 || state_q == StShow2) ? DwellLimit : BlankLimit;

  scan_timer u_scan_timer (
    .clk_i   (Clk),
    .rst_ni  (Rst_n),
    .clear_i (timer_clear),
    .limit_i (limit),
    .tc_o    (tc)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   state_d = StShow1;
      StShow1:  if (tc) state_d = StBlank1;
      StBlank1: if (tc) state_d = StShow2;
      StShow2:  if (tc) state_d = StBlank2;
      StBlank2: if (tc) state_d = StShow1;
      default:  state_d = StIdle;
    endcase
    if (!Enable) state_d = StIdle;

    // Counter restarts on every state entry and is held at zero while idle.
    timer_clear = (state_d != state_q) || (state_q == StIdle);
    commit      = (state_d == StShow1) && (state_q == StIdle || state_q == StBlank2);

    stage1_d  = stage1_q;
    stage2_d  = stage2_q;
    pending_d = pending_q;
    if (Load) begin
      stage1_d  = SevenSegDig1;
      stage2_d  = SevenSegDig2;
      pending_d = 1'b1;
    end

    // A Load in the commit cycle goes straight to the display through stage*_d.
    disp1_d = disp1_q;
    disp2_d = disp2_q;
    ack_d   = 1'b0;
    if (commit && pending_d) begin
      disp1_d   = stage1_d;
      disp2_d   = stage2_d;
      pending_d = 1'b0;
      ack_d     = 1'b1;
    end

    seg_d = '0;
    dig_d = 2'b00;
    if (state_d == StShow1) begin
      seg_d = disp1_d;
      dig_d = 2'b01;
    end else if (state_d == StShow2) begin
      seg_d = disp2_d;
      dig_d = 2'b10;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= StIdle;
      stage1_q  <= '0;
      stage2_q  <= '0;
      disp1_q   <= '0;
      disp2_q   <= '0;
      pending_q <= 1'b0;
      seg_q     <= '0;
      dig_q     <= 2'b00;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      stage1_q  <= stage1_d;
      stage2_q  <= stage2_d;
      disp1_q   <= disp1_d;
      disp2_q   <= disp2_d;
      pending_q <= pending_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
      ack_q     <= ack_d;
    end
  end

  assign SegOut    = seg_q;
  assign DigitEn   = dig_q;
  assign LoadAck   = ack_q;
  assign FrameDone = (state_q == StBlank2) && tc;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Self-checking bench: directed vector table, async-reset sequences and a randomized model run.
module tb_seven_seg_scan_driver;

  localparam int D = 4;
  localparam int B = 1;
  localparam int F = 2 * (D + B);

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       ld = 1'b0;
  logic [7:0] d1 = '0;
  logic [7:0] d2 = '0;
  logic [7:0] seg;
  logic [1:0] den;
  logic       fd;
  logic       ack;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(
    .DWELL_CYCLES (D),
    .BLANK_CYCLES (B)
  ) dut (
    .Clk          (clk),
    .Rst_n        (rst_n),
    .Enable       (en),
    .Load         (ld),
    .SevenSegDig1 (d1),
    .SevenSegDig2 (d2),
    .SegOut       (seg),
    .DigitEn      (den),
    .FrameDone    (fd),
    .LoadAck      (ack)
  );

  // Reference model: position within a frame plus staging/display registers.
  bit         m_act;
  int         m_pos;
  bit         m_pend;
  bit         m_ack;
  logic [7:0] m_s1, m_s2, m_p1, m_p2;

  function automatic void model_reset();
    m_act = 0; m_pos = 0; m_pend = 0; m_ack = 0;
    m_s1 = '0; m_s2 = '0; m_p1 = '0; m_p2 = '0;
  endfunction

  function automatic void model_step(bit e, bit l, logic [7:0] a, logic [7:0] b);
    bit entering;
    entering = e && (!m_act || m_pos == F - 1);
    if (!e) begin
      m_act = 0;
      m_pos = 0;
    end else if (!m_act) begin
      m_act = 1;
      m_pos = 0;
    end else begin
      m_pos = (m_pos + 1) % F;
    end
    m_ack = 0;
    if (l) begin
      m_s1 = a; m_s2 = b; m_pend = 1;
    end
    if (entering && m_pend) begin
      m_p1 = m_s1; m_p2 = m_s2; m_pend = 0; m_ack = 1;
    end
  endfunction

  task automatic check(string name, logic [7:0] es, logic [1:0] ed, logic ef, logic ea);
    n_tests++;
    if (seg !== es || den !== ed || fd !== ef || ack !== ea) begin
      n_fail++;
      $display("FAIL %s: got seg=%h den=%b fd=%b ack=%b, want seg=%h den=%b fd=%b ack=%b",
               name, seg, den, fd, ack, es, ed, ef, ea);
    end
  endtask

  task automatic check_model(string name);
    logic [7:0] s;
    logic [1:0] d;
    logic       f;
    s = '0; d = 2'b00; f = 1'b0;
    if (m_act) begin
      if (m_pos < D) begin
        s = m_p1; d = 2'b01;
      end else if (m_pos >= D + B && m_pos < 2 * D + B) begin
        s = m_p2; d = 2'b10;
      end
      f = (m_pos == F - 1);
    end
    check(name, s, d, f, m_ack);
  endtask

  task automatic step(bit e, bit l, logic [7:0] a, logic [7:0] b);
    en = e; ld = l; d1 = a; d2 = b;
    @(posedge clk);
    model_step(e, l, a, b);
    #1;
  endtask

  typedef struct {
    bit         en;
    bit         ld;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [7:0] seg;
    logic [1:0] den;
    bit         fd;
    bit         ack;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit e, bit l, logic [7:0] a, logic [7:0] b,
                              logic [7:0] s, logic [1:0] d, bit f, bit k);
    vec_t v;
    v.en = e; v.ld = l; v.d1 = a; v.d2 = b; v.seg = s; v.den = d; v.fd = f; v.ack = k;
    tbl.push_back(v);
  endfunction

  // One full enabled frame; unrelated data on the pattern inputs must never be captured.
  function automatic void add_frame(logic [7:0] p1, logic [7:0] p2, bit first_ack);
    for (int i = 0; i < D; i++) add(1, 0, 8'hEE, 8'hDD, p1, 2'b01, 0, first_ack && i == 0);
    for (int i = 0; i < B; i++) add(1, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);
    for (int i = 0; i < D; i++) add(1, 0, 8'hEE, 8'hDD, p2, 2'b10, 0, 0);
    for (int i = 0; i < B; i++) add(1, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, i == B - 1, 0);
  endfunction

  initial begin
    model_reset();

    // Reset held with arbitrary inputs: outputs stay quiet, including before any edge.
    en = 1'b1; ld = 1'b1; d1 = 8'hFF; d2 = 8'hFF;
    #1;
    check("reset_t0", 8'h00, 2'b00, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      en = 1'($urandom); ld = 1'($urandom); d1 = 8'($urandom); d2 = 8'($urandom);
      @(posedge clk); #1;
      check("reset_hold", 8'h00, 2'b00, 1'b0, 1'b0);
    end
    en = 0; ld = 0; d1 = '0; d2 = '0;
    rst_n = 1'b1;

    add(0, 1, 8'h07, 8'h71, 8'h00, 2'b00, 0, 0);      // load while idle
    add_frame(8'h07, 8'h71, 1);                        // entries 1..10
    add_frame(8'h07, 8'h71, 0);                        // entries 11..20
    add_frame(8'h3F, 8'h06, 1);                        // entries 21..30
    add_frame(8'h5B, 8'h4F, 1);                        // entries 31..40
    tbl[17].ld = 1; tbl[17].d1 = 8'h3F; tbl[17].d2 = 8'h06;   // load during SHOW2
    tbl[31].ld = 1; tbl[31].d1 = 8'h5B; tbl[31].d2 = 8'h4F;   // load in FrameDone cycle
    for (int i = 0; i < D; i++) add(1, 0, 8'hEE, 8'hDD, 8'h5B, 2'b01, 0, 0);
    add(1, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);
    add(1, 0, 8'hEE, 8'hDD, 8'h4F, 2'b10, 0, 0);
    add(1, 0, 8'hEE, 8'hDD, 8'h4F, 2'b10, 0, 0);
    add(0, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);      // disable in 2nd SHOW2 cycle
    add(0, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);
    add(0, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);
    for (int i = 0; i < D; i++) add(1, 0, 8'hEE, 8'hDD, 8'h5B, 2'b01, 0, 0);
    add(1, 0, 8'hEE, 8'hDD, 8'h00, 2'b00, 0, 0);

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].ld, tbl[i].d1, tbl[i].d2);
      check($sformatf("vec%0d", i), tbl[i].seg, tbl[i].den, tbl[i].fd, tbl[i].ack);
    end

    // Reset mid-SHOW1 with a load pending: pending data is discarded.
    for (int i = 0; i < D + B + 1; i++) begin
      step(1, 0, 8'h00, 8'h00);
      check_model("pre_reset");
    end
    step(1, 1, 8'hAA, 8'hBB);
    check_model("pre_reset_load");
    rst_n = 1'b0;
    #1;
    check("reset_async", 8'h00, 2'b00, 1'b0, 1'b0);
    model_reset();
    @(posedge clk); #1;
    check("reset_mid", 8'h00, 2'b00, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < F; i++) begin
      step(1, 0, 8'h00, 8'h00);
      if (i < D)
        check("post_reset_show1", 8'h00, 2'b01, 1'b0, 1'b0);
      else if (i >= D + B && i < 2 * D + B)
        check("post_reset_show2", 8'h00, 2'b10, 1'b0, 1'b0);
      else
        check("post_reset_blank", 8'h00, 2'b00, i == F - 1, 1'b0);
    end

    // Randomized run against the frame-position model.
    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 15) != 0, $urandom_range(0, 9) == 0, 8'($urandom), 8'($urandom));
      check_model("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
